// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: splits loads/stores into BUS_BYTES-wide beats towards the memory
// controller and presents the sign/zero-extended result (or the ALU pass-through) to write-back.
module mem_lsu #(
  parameter int XLEN      = 32,
  parameter int BUS_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en_i,
  input  logic                   store_en_i,
  input  logic [2:0]             funct3_i,
  input  logic [XLEN-1:0]        addr_i,
  input  logic [XLEN-1:0]        data_i,
  input  logic [4:0]             rd_addr_i,
  input  logic                   rd_we_i,
  output logic                   stall_req_o,
  output logic                   mem_req_o,
  output logic                   mem_wr_o,
  output logic [XLEN-1:0]        mem_addr_o,
  output logic [BUS_BYTES-1:0]   mem_be_o,
  output logic [8*BUS_BYTES-1:0] mem_wdata_o,
  input  logic [8*BUS_BYTES-1:0] mem_rdata_i,
  input  logic                   mem_ack_i,
  output logic [XLEN-1:0]        rd_data_o,
  output logic [4:0]             rd_addr_o,
  output logic                   rd_we_o
);

  localparam logic [3:0] BB = 4'(BUS_BYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        last_q;
  logic              is_load_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [3:0]        size_q;
  logic [XLEN-1:0]   buf_q, buf_d;

  logic              capture;
  logic              in_access;
  logic [3:0]        size_in;
  logic [3:0]        off_in;
  logic [2:0]        last_in;
  logic [3:0]        off_q;
  logic [3:0]        kbase;
  logic [XLEN-1:0]   base_q;
  logic [BUS_BYTES-1:0]   lane_en;
  logic [8*BUS_BYTES-1:0] lane_wdata;

  // Loads decode LBU/LHU through funct3[1:0]; stores only recognise SB/SH exactly.
  always_comb begin
    size_in = 4'd4;
    if (load_en_i) begin
      case (funct3_i[1:0])
        2'b00:   size_in = 4'd1;
        2'b01:   size_in = 4'd2;
        default: size_in = 4'd4;
      endcase
    end else begin
      case (funct3_i)
        3'b000:  size_in = 4'd1;
        3'b001:  size_in = 4'd2;
        default: size_in = 4'd4;
      endcase
    end
    off_in  = {2'b00, addr_i[1:0]} & (BB - 4'd1);
    last_in = 3'((off_in + size_in - 4'd1) / BB);
  end

  assign capture   = (state_q == IDLE) && (load_en_i || store_en_i);
  assign in_access = (state_q == ACCESS);
  assign off_q     = {2'b00, addr_q[1:0]} & (BB - 4'd1);
  assign kbase     = {1'b0, k_q} * BB;
  assign base_q    = addr_q & ~(XLEN'(BUS_BYTES - 1));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    stall_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_en_i || store_en_i) begin
          stall_req_o = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        stall_req_o = 1'b1;
        if (mem_ack_i) begin
          k_d = k_q + 3'd1;
          if (k_q == last_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane l of beat k carries access byte rel = k*BUS_BYTES + l - off.
  always_comb begin : lane_map
    logic [3:0] pos;
    logic [1:0] rel;
    lane_en    = '0;
    lane_wdata = '0;
    buf_d      = buf_q;
    pos        = '0;
    rel        = '0;
    for (int l = 0; l < BUS_BYTES; l++) begin
      pos        = kbase + 4'(l);
      rel        = 2'(pos - off_q);
      lane_en[l] = (pos >= off_q) && (pos < off_q + size_q);
      if (lane_en[l]) begin
        lane_wdata[8*l +: 8] = wdata_q[{rel, 3'b000} +: 8];
        if (in_access && mem_ack_i && is_load_q)
          buf_d[{rel, 3'b000} +: 8] = mem_rdata_i[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      last_q    <= '0;
      is_load_q <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      buf_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
      if (capture) begin
        is_load_q <= load_en_i;
        funct3_q  <= funct3_i;
        addr_q    <= addr_i;
        wdata_q   <= data_i;
        size_q    <= size_in;
        last_q    <= last_in;
        k_q       <= '0;
        buf_q     <= '0;
      end
    end
  end

  assign mem_req_o   = in_access;
  assign mem_wr_o    = in_access && !is_load_q;
  assign mem_addr_o  = in_access ? base_q + XLEN'(kbase) : '0;
  assign mem_be_o    = in_access ? lane_en : '0;
  assign mem_wdata_o = (in_access && !is_load_q) ? lane_wdata : '0;

  always_comb begin
    rd_data_o = data_i;
    if (state_q == DONE && is_load_q) begin
      case (funct3_q)
        3'b000:  rd_data_o = {{(XLEN-8){buf_q[7]}}, buf_q[7:0]};
        3'b001:  rd_data_o = {{(XLEN-16){buf_q[15]}}, buf_q[15:0]};
        3'b100:  rd_data_o = {{(XLEN-8){1'b0}}, buf_q[7:0]};
        3'b101:  rd_data_o = {{(XLEN-16){1'b0}}, buf_q[15:0]};
        default: rd_data_o = buf_q;
      endcase
    end
  end

  assign rd_addr_o = rd_addr_i;
  assign rd_we_o   = rd_we_i;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: three instances (BUS_BYTES 1/2/4) share the pipeline inputs; a byte-array
// memory model answers whichever instance is selected and a beat scoreboard checks every request.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en, store_en;
  logic [2:0]  funct3;
  logic [31:0] addr, data;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [31:0] rdata;
  logic        model_ack, stale_ack, ack_all;
  int          sel;
  int          ack_delay, wait_cnt, acked;
  int          n_checks, n_fail;
  logic [7:0]  mem [0:65535];
  logic [68:0] exp_q[$];

  logic        req1, wr1, stall1, we1;
  logic [31:0] maddr1, rdd1;
  logic [0:0]  be1;
  logic [7:0]  wd1;
  logic [4:0]  rda1;
  logic        req2, wr2, stall2, we2;
  logic [31:0] maddr2, rdd2;
  logic [1:0]  be2;
  logic [15:0] wd2;
  logic [4:0]  rda2;
  logic        req4, wr4, stall4, we4;
  logic [31:0] maddr4, rdd4;
  logic [3:0]  be4;
  logic [31:0] wd4;
  logic [4:0]  rda4;

  logic        req_s, wr_s, stall_s, we_s;
  logic [31:0] addr_s, wdata_s, rd_data_s;
  logic [3:0]  be_s;
  logic [4:0]  rda_s;

  always #5 clk = ~clk;
  assign ack_all = model_ack | stale_ack;

  mem_lsu #(.XLEN(32), .BUS_BYTES(1)) u1 (
    .clk(clk), .rst(rst), .load_en_i(load_en), .store_en_i(store_en), .funct3_i(funct3),
    .addr_i(addr), .data_i(data), .rd_addr_i(rd_addr), .rd_we_i(rd_we),
    .stall_req_o(stall1), .mem_req_o(req1), .mem_wr_o(wr1), .mem_addr_o(maddr1),
    .mem_be_o(be1), .mem_wdata_o(wd1), .mem_rdata_i(rdata[7:0]), .mem_ack_i(ack_all && sel == 1),
    .rd_data_o(rdd1), .rd_addr_o(rda1), .rd_we_o(we1));

  mem_lsu #(.XLEN(32), .BUS_BYTES(2)) u2 (
    .clk(clk), .rst(rst), .load_en_i(load_en), .store_en_i(store_en), .funct3_i(funct3),
    .addr_i(addr), .data_i(data), .rd_addr_i(rd_addr), .rd_we_i(rd_we),
    .stall_req_o(stall2), .mem_req_o(req2), .mem_wr_o(wr2), .mem_addr_o(maddr2),
    .mem_be_o(be2), .mem_wdata_o(wd2), .mem_rdata_i(rdata[15:0]), .mem_ack_i(ack_all && sel == 2),
    .rd_data_o(rdd2), .rd_addr_o(rda2), .rd_we_o(we2));

  mem_lsu #(.XLEN(32), .BUS_BYTES(4)) u4 (
    .clk(clk), .rst(rst), .load_en_i(load_en), .store_en_i(store_en), .funct3_i(funct3),
    .addr_i(addr), .data_i(data), .rd_addr_i(rd_addr), .rd_we_i(rd_we),
    .stall_req_o(stall4), .mem_req_o(req4), .mem_wr_o(wr4), .mem_addr_o(maddr4),
    .mem_be_o(be4), .mem_wdata_o(wd4), .mem_rdata_i(rdata), .mem_ack_i(ack_all && sel == 4),
    .rd_data_o(rdd4), .rd_addr_o(rda4), .rd_we_o(we4));

  always_comb begin
    {req_s, wr_s, stall_s, we_s} = {req4, wr4, stall4, we4};
    {addr_s, wdata_s, rd_data_s, be_s, rda_s} = {maddr4, wd4, rdd4, be4, rda4};
    if (sel == 1) begin
      {req_s, wr_s, stall_s, we_s} = {req1, wr1, stall1, we1};
      {addr_s, wdata_s, rd_data_s, be_s, rda_s} = {maddr1, 24'h0, wd1, rdd1, 3'b000, be1, rda1};
    end else if (sel == 2) begin
      {req_s, wr_s, stall_s, we_s} = {req2, wr2, stall2, we2};
      {addr_s, wdata_s, rd_data_s, be_s, rda_s} = {maddr2, 16'h0, wd2, rdd2, 2'b00, be2, rda2};
    end
  end

  // Memory controller model: answers after ack_delay wait cycles per beat.
  always @(posedge clk) begin
    #2;
    model_ack = 1'b0;
    if (req_s && !rst) begin
      if (wait_cnt < ack_delay) begin
        wait_cnt++;
      end else begin
        model_ack = 1'b1;
        wait_cnt  = 0;
        for (int l = 0; l < 4; l++) rdata[8*l +: 8] = mem[16'(addr_s[15:0] + 16'(l))];
        if (wr_s)
          for (int l = 0; l < 4; l++)
            if (be_s[l]) mem[16'(addr_s[15:0] + 16'(l))] = wdata_s[8*l +: 8];
      end
    end
  end

  // Beat scoreboard: every request cycle must match the head entry, which retires on ack.
  always @(negedge clk) begin
    logic [68:0] e;
    logic [31:0] mask;
    if (req_s && !rst) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got wr=%0b be=%b addr=%h, required no beat", wr_s, be_s, addr_s);
      end else begin
        e = exp_q[0];
        for (int l = 0; l < 4; l++) mask[8*l +: 8] = {8{e[64+l]}};
        if ({wr_s, be_s, addr_s} !== e[68:32] || (wr_s && ((wdata_s & mask) !== e[31:0]))) begin
          n_fail++;
          $display("FAIL beat: got wr=%0b be=%b addr=%h wdata=%h, required wr=%0b be=%b addr=%h wdata=%h",
                   wr_s, be_s, addr_s, wdata_s & mask, e[68], e[67:64], e[63:32], e[31:0]);
        end
        if (ack_all) begin
          void'(exp_q.pop_front());
          acked++;
        end
      end
    end
  end

  function automatic logic [68:0] mk(input logic wr, input logic [3:0] be, input logic [31:0] a,
                                     input logic [31:0] wd);
    return {wr, be, a, wd};
  endfunction

  task automatic do_access(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] res, output int stalls);
    logic done;
    logic done_req;
    done = 1'b0;
    done_req = 1'b0;
    stalls = 0;
    res = '0;
    @(posedge clk); #1;
    load_en = ld; store_en = st; funct3 = f3; addr = a; data = d;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (stall_s) stalls++;
      else begin
        done = 1'b1;
        res = rd_data_s;
        done_req = req_s;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL access_timeout: got stall still high after 60 cycles, required DONE");
    end
    n_checks++;
    if (done_req !== 1'b0) begin
      n_fail++;
      $display("FAIL done_req: got %b, required 0", done_req);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL beats_left: got %0d beats outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
    @(posedge clk); #1;
    load_en = 1'b0; store_en = 1'b0;
  endtask

  task automatic test_reset(input int s);
    @(negedge clk);
    rst = 1'b1; sel = s;
    load_en = 1'b0; store_en = 1'b0; funct3 = '0; addr = '0; data = '0; rd_addr = '0; rd_we = 1'b0;
    exp_q.delete(); wait_cnt = 0; ack_delay = 0; stale_ack = 1'b0;
    #2;
    n_checks++;
    if ({req_s, wr_s, stall_s, be_s} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req=%b wr=%b stall=%b be=%b, required all 0", req_s, wr_s, stall_s, be_s);
    end
    n_checks++;
    if ({addr_s, wdata_s} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%h wdata=%h, required 0", addr_s, wdata_s);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_passthrough;
    @(posedge clk); #1;
    data = 32'h0000_1234; rd_addr = 5'd5; rd_we = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rd_data_s !== 32'h0000_1234 || rda_s !== 5'd5 || we_s !== 1'b1) begin
      n_fail++;
      $display("FAIL passthrough_wb: got data=%h rd=%0d we=%b, required 00001234 5 1", rd_data_s, rda_s, we_s);
    end
    n_checks++;
    if (stall_s !== 1'b0 || req_s !== 1'b0) begin
      n_fail++;
      $display("FAIL passthrough_ctrl: got stall=%b req=%b, required 0 0", stall_s, req_s);
    end
    @(posedge clk); #1;
    rd_we = 1'b0; rd_addr = '0;
  endtask

  task automatic check_res(input string name, input logic [31:0] got, input logic [31:0] req,
                           input int got_st, input int req_st);
    n_checks++;
    if (got !== req || got_st != req_st) begin
      n_fail++;
      $display("FAIL %s: got rd_data=%h stalls=%0d, required rd_data=%h stalls=%0d", name, got, got_st, req, req_st);
    end
  endtask

  task automatic test_lw_serial;
    logic [31:0] r;
    int st;
    mem[16'h1000] = 8'h11; mem[16'h1001] = 8'h22; mem[16'h1002] = 8'h33; mem[16'h1003] = 8'h44;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 4'b0001, 32'h1000 + i, 32'h0));
    do_access(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, r, st);
    if (1) check_res("lw_b1", r, 32'h4433_2211, st, 5);
  endtask

  task automatic test_lb_sign;
    logic [31:0] r;
    int st;
    mem[16'h2000] = 8'h80;
    exp_q.push_back(mk(1'b0, 4'b0001, 32'h2000, 32'h0));
    do_access(1'b1, 1'b0, 3'b000, 32'h2000, 32'h0, r, st);
    check_res("lb_sign", r, 32'hFFFF_FF80, st, 2);
    exp_q.push_back(mk(1'b0, 4'b0001, 32'h2000, 32'h0));
    do_access(1'b1, 1'b0, 3'b100, 32'h2000, 32'h0, r, st);
    check_res("lbu_zero", r, 32'h0000_0080, st, 2);
  endtask

  task automatic test_reset_midflight;
    logic [31:0] r;
    int st;
    mem[16'h3000] = 8'h5A; mem[16'h3001] = 8'h6B; mem[16'h3002] = 8'h7C; mem[16'h3003] = 8'h8D;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 4'b0001, 32'h3000 + i, 32'h0));
    acked = 0;
    @(posedge clk); #1;
    load_en = 1'b1; funct3 = 3'b010; addr = 32'h3000;
    for (int c = 0; c < 40 && acked < 2; c++) @(negedge clk);
    n_checks++;
    if (acked != 2) begin
      n_fail++;
      $display("FAIL midflight_acks: got %0d acks, required 2", acked);
    end
    @(posedge clk); #1;
    rst = 1'b1; load_en = 1'b0;
    #1;
    n_checks++;
    if (req_s !== 1'b0 || stall_s !== 1'b0 || be_s !== 4'b0 || addr_s !== 32'h0) begin
      n_fail++;
      $display("FAIL midflight_reset: got req=%b stall=%b be=%b addr=%h, required 0 0 0 0", req_s, stall_s, be_s, addr_s);
    end
    exp_q.delete(); wait_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0; stale_ack = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    stale_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_s !== 1'b0 || stall_s !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_ack: got req=%b stall=%b, required 0 0", req_s, stall_s);
    end
    exp_q.push_back(mk(1'b0, 4'b0001, 32'h3000, 32'h0));
    do_access(1'b1, 1'b0, 3'b100, 32'h3000, 32'h0, r, st);
    check_res("after_reset_lbu", r, 32'h0000_005A, st, 2);
  endtask

  task automatic test_sh_split;
    logic [31:0] r;
    int st;
    exp_q.push_back(mk(1'b1, 4'b0010, 32'h1002, 32'h0000_EF00));
    exp_q.push_back(mk(1'b1, 4'b0001, 32'h1004, 32'h0000_00BE));
    do_access(1'b0, 1'b1, 3'b001, 32'h1003, 32'h0000_BEEF, r, st);
    check_res("sh_b2", r, 32'h0000_BEEF, st, 3);
    n_checks++;
    if ({mem[16'h1002], mem[16'h1003], mem[16'h1004]} !== 24'h33_EF_BE) begin
      n_fail++;
      $display("FAIL sh_mem: got %h %h %h, required 33 ef be", mem[16'h1002], mem[16'h1003], mem[16'h1004]);
    end
  endtask

  task automatic test_lw_wait;
    logic [31:0] r;
    int st;
    mem[16'h4000] = 8'hDE; mem[16'h4001] = 8'hAD; mem[16'h4002] = 8'hBE; mem[16'h4003] = 8'hEF;
    ack_delay = 3;
    exp_q.push_back(mk(1'b0, 4'b1111, 32'h4000, 32'h0));
    do_access(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, r, st);
    check_res("lw_b4_wait", r, 32'hEFBE_ADDE, st, 5);
    ack_delay = 0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    int st;
    exp_q.push_back(mk(1'b1, 4'b0010, 32'h4000, 32'h0000_7700));
    do_access(1'b0, 1'b1, 3'b000, 32'h4001, 32'h1234_5677, r, st);
    check_res("sb_b4", r, 32'h1234_5677, st, 2);
    n_checks++;
    if (mem[16'h4001] !== 8'h77 || mem[16'h4000] !== 8'hDE) begin
      n_fail++;
      $display("FAIL sb_mem: got %h %h, required de 77", mem[16'h4000], mem[16'h4001]);
    end
    mem[16'h4004] = 8'h85;
    exp_q.push_back(mk(1'b0, 4'b1000, 32'h4000, 32'h0));
    exp_q.push_back(mk(1'b0, 4'b0001, 32'h4004, 32'h0));
    do_access(1'b1, 1'b0, 3'b001, 32'h4003, 32'h0, r, st);
    check_res("lh_split_b4", r, 32'hFFFF_85EF, st, 3);
    exp_q.push_back(mk(1'b0, 4'b1000, 32'h4000, 32'h0));
    exp_q.push_back(mk(1'b0, 4'b0001, 32'h4004, 32'h0));
    do_access(1'b1, 1'b0, 3'b101, 32'h4003, 32'h0, r, st);
    check_res("lhu_split_b4", r, 32'h0000_85EF, st, 3);
  endtask

  initial begin
    rst = 1'b1; sel = 1;
    load_en = 1'b0; store_en = 1'b0; funct3 = '0; addr = '0; data = '0; rd_addr = '0; rd_we = 1'b0;
    rdata = '0; model_ack = 1'b0; stale_ack = 1'b0;
    ack_delay = 0; wait_cnt = 0; acked = 0; n_checks = 0; n_fail = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset(1);
    test_passthrough;
    test_lw_serial;
    test_lb_sign;
    test_reset_midflight;
    test_reset(2);
    test_sh_split;
    test_reset(4);
    test_lw_wait;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
